// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory stage: FSM state encoding, funct3 access
// widths and the sign-extension helper used by the load path.
package mem_stage_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REQ      = 2'd1;
  localparam logic [1:0] ST_WAIT_RSP = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Sign-extend the low byte (is_half=0) or low halfword (is_half=1).
  function automatic logic [31:0] sext(input logic [31:0] val, input logic is_half);
    return is_half ? {{16{val[15]}}, val[15:0]} : {{24{val[7]}}, val[7:0]};
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load lane selection and extension: aligns the addressed bytes of a bus word
// down to bit 0 and sign/zero-extends according to funct3.
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_addr, 3'b000};

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_B:    o_data = sext(w_shifted, 1'b0);
      F3_H:    o_data = sext(w_shifted, 1'b1);
      F3_W:    o_data = w_shifted;
      F3_BU:   o_data = {24'b0, w_shifted[7:0]};
      F3_HU:   o_data = {16'b0, w_shifted[15:0]};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: captures the execute result, runs one bus transaction
// for loads/stores, then presents write-back data. Option: MEM_MISALIGN_CHECK_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc,
  input  logic [3:0]      csr_wen,
  input  logic            R_wen,
  input  logic            mem_wen,
  input  logic            mem_ren,
  input  logic [4:0]      rd,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs2_value,
  input  logic [XLEN-1:0] csrs,
  input  logic [XLEN-1:0] EX_result,
  input  logic            branch_flag,
  input  logic            jump_flag,

  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  output logic            req_wen,
  output logic [XLEN-1:0] req_wdata,
  output logic [3:0]      req_wmask,
  input  logic            rsp_valid,
  input  logic [XLEN-1:0] rsp_rdata,

  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_next,
  output logic [4:0]      rd_next,
  output logic            R_wen_next,
  output logic [3:0]      csr_wen_next,
  output logic [XLEN-1:0] csrs_next,
  output logic            branch_flag_next,
  output logic            jump_flag_next,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic            misalign_err,
`endif
  output logic [XLEN-1:0] wb_data
);

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic [3:0]      r_csr_wen;
  logic            r_rwen;
  logic            r_mem_wen;
  logic            r_mem_ren;
  logic [4:0]      r_rd;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_rs2;
  logic [XLEN-1:0] r_csrs;
  logic [XLEN-1:0] r_ex_result;
  logic            r_branch;
  logic            r_jump;
  logic [XLEN-1:0] r_rdata;
  logic            r_misalign;

  logic            w_accept;
  logic            w_misalign_in;
  logic [1:0]      w_accept_state;
  logic            w_is_load;
  logic [XLEN-1:0] w_load_data;
  logic [XLEN-1:0] w_wdata;
  logic [3:0]      w_wmask;

  assign in_ready = (r_state == ST_IDLE) || (r_state == ST_DONE && out_ready);
  assign w_accept = in_valid && in_ready;

`ifdef MEM_MISALIGN_CHECK_EN
  assign w_misalign_in = (mem_wen || mem_ren) &&
                         ((funct3[1:0] == 2'b01 && EX_result[0]) ||
                          (funct3[1:0] == 2'b10 && EX_result[1:0] != 2'b00));
  assign misalign_err  = r_misalign;
`else
  assign w_misalign_in = 1'b0;
`endif

  assign w_accept_state = ((mem_wen || mem_ren) && !w_misalign_in) ? ST_REQ : ST_DONE;

  // NOTE: sequential state uses non-blocking assignments; the async reset clears every
  // captured field so an aborted transaction leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_csr_wen   <= '0;
      r_rwen      <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_ren   <= 1'b0;
      r_rd        <= '0;
      r_funct3    <= '0;
      r_rs2       <= '0;
      r_csrs      <= '0;
      r_ex_result <= '0;
      r_branch    <= 1'b0;
      r_jump      <= 1'b0;
      r_rdata     <= '0;
      r_misalign  <= 1'b0;
    end else if (w_accept) begin
      r_state     <= w_accept_state;
      r_pc        <= pc;
      r_csr_wen   <= csr_wen;
      r_rwen      <= R_wen;
      r_mem_wen   <= mem_wen;
      r_mem_ren   <= mem_ren;
      r_rd        <= rd;
      r_funct3    <= funct3;
      r_rs2       <= rs2_value;
      r_csrs      <= csrs;
      r_ex_result <= EX_result;
      r_branch    <= branch_flag;
      r_jump      <= jump_flag;
      r_misalign  <= w_misalign_in;
    end else begin
      case (r_state)
        ST_REQ:      if (req_ready) r_state <= ST_WAIT_RSP;
        ST_WAIT_RSP: if (rsp_valid) begin
          r_rdata <= rsp_rdata;
          r_state <= ST_DONE;
        end
        ST_DONE:     if (out_ready) r_state <= ST_IDLE;
        default:     r_state <= r_state;
      endcase
    end
  end

  // A store wins when both enables are set.
  always_comb begin
    w_wdata = r_rs2;
    w_wmask = '0;
    case (r_funct3)
      F3_B: begin
        w_wdata = {4{r_rs2[7:0]}};
        w_wmask = 4'b0001 << r_ex_result[1:0];
      end
      F3_H: begin
        w_wdata = {2{r_rs2[15:0]}};
        w_wmask = 4'b0011 << {r_ex_result[1], 1'b0};
      end
      F3_W:    w_wmask = 4'b1111;
      default: w_wmask = '0;
    endcase
  end

  assign req_valid = (r_state == ST_REQ);
  assign req_addr  = {r_ex_result[XLEN-1:2], 2'b00};
  assign req_wen   = r_mem_wen;
  assign req_wdata = w_wdata;
  assign req_wmask = r_mem_wen ? w_wmask : 4'b0000;

  mem_load_ext u_load_ext (
    .i_rdata  (r_rdata),
    .i_addr   (r_ex_result[1:0]),
    .i_funct3 (r_funct3),
    .o_data   (w_load_data)
  );

  assign w_is_load = r_mem_ren && !r_mem_wen && !r_misalign;

  assign out_valid        = (r_state == ST_DONE);
  assign wb_data          = w_is_load ? w_load_data : r_ex_result;
  assign pc_next          = r_pc;
  assign rd_next          = r_rd;
  assign R_wen_next       = r_rwen && !r_misalign;
  assign csr_wen_next     = r_csr_wen;
  assign csrs_next        = r_csrs;
  assign branch_flag_next = r_branch;
  assign jump_flag_next   = r_jump;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU pass-through, load/store lane
// handling, bus stalls, output back-pressure and reset mid-transaction.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] pc;
  logic [3:0]  csr_wen;
  logic        R_wen, mem_wen, mem_ren;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [31:0] rs2_value, csrs, EX_result;
  logic        branch_flag, jump_flag;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wmask;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        out_valid, out_ready;
  logic [31:0] pc_next;
  logic [4:0]  rd_next;
  logic        R_wen_next;
  logic [3:0]  csr_wen_next;
  logic [31:0] csrs_next;
  logic        branch_flag_next, jump_flag_next;
  logic [31:0] wb_data;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .csr_wen(csr_wen), .R_wen(R_wen), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .rd(rd), .funct3(funct3), .rs2_value(rs2_value), .csrs(csrs), .EX_result(EX_result),
    .branch_flag(branch_flag), .jump_flag(jump_flag),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wen(req_wen),
    .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .pc_next(pc_next), .rd_next(rd_next),
    .R_wen_next(R_wen_next), .csr_wen_next(csr_wen_next), .csrs_next(csrs_next),
    .branch_flag_next(branch_flag_next), .jump_flag_next(jump_flag_next),
`ifdef MEM_MISALIGN_CHECK_EN
    .misalign_err(misalign_err),
`endif
    .wb_data(wb_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one execute result at a negedge; returns 1ns after the accepting edge.
  task automatic start_op(input logic [31:0] a_pc, input logic [31:0] a_ex,
                          input logic [31:0] a_rs2, input logic [2:0] a_f3,
                          input logic a_wen, input logic a_ren,
                          input logic [4:0] a_rd, input logic a_rwen);
    @(negedge clk);
    pc = a_pc; EX_result = a_ex; rs2_value = a_rs2; funct3 = a_f3;
    mem_wen = a_wen; mem_ren = a_ren; rd = a_rd; R_wen = a_rwen;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    #1 check("in_ready_before_accept", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
  endtask

  // Grant the request, then return a response; ends at the negedge after DONE is reached.
  task automatic bus_xfer(input logic [31:0] rdata);
    @(negedge clk);
    in_valid  = 1'b0;
    req_ready = 1'b1;
    @(posedge clk);
    #1 check("req_valid_after_grant", 32'(req_valid), 32'h0);
    check("out_valid_wait_rsp", 32'(out_valid), 32'h0);
    @(negedge clk);
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_rdata = rdata;
    @(posedge clk);
    #1 check("out_valid_after_rsp", 32'(out_valid), 32'h1);
    @(negedge clk);
    rsp_valid = 1'b0;
    rsp_rdata = 32'h0;
  endtask

  task automatic finish_op();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1 check("out_valid_cleared", 32'(out_valid), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; pc = '0; csr_wen = '0; R_wen = 1'b0;
    mem_wen = 1'b0; mem_ren = 1'b0; rd = '0; funct3 = '0; rs2_value = '0;
    csrs = '0; EX_result = '0; branch_flag = 1'b0; jump_flag = 1'b0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0; out_ready = 1'b0;

    #12;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_req_valid", 32'(req_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_pc_next", pc_next, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // ALU op: result one cycle after accept, bus untouched
    csr_wen = 4'h3; csrs = 32'h0000CAFE; branch_flag = 1'b1; jump_flag = 1'b0;
    start_op(32'h0000_0100, 32'h0000_1234, 32'h0, 3'b000, 1'b0, 1'b0, 5'd5, 1'b1);
    check("alu_out_valid", 32'(out_valid), 32'h1);
    check("alu_req_valid", 32'(req_valid), 32'h0);
    check("alu_wb_data", wb_data, 32'h0000_1234);
    check("alu_pc_next", pc_next, 32'h0000_0100);
    check("alu_rd_next", 32'(rd_next), 32'd5);
    check("alu_R_wen_next", 32'(R_wen_next), 32'h1);
    check("alu_csr_wen_next", 32'(csr_wen_next), 32'h3);
    check("alu_csrs_next", csrs_next, 32'h0000CAFE);
    check("alu_branch_next", 32'(branch_flag_next), 32'h1);
    check("alu_jump_next", 32'(jump_flag_next), 32'h0);
    finish_op();
    check("alu_req_valid_idle", 32'(req_valid), 32'h0);
    csr_wen = 4'h0; csrs = 32'h0; branch_flag = 1'b0;

    // LB from the top byte lane
    start_op(32'h0000_0200, 32'h8000_0003, 32'h0, 3'b000, 1'b0, 1'b1, 5'd6, 1'b1);
    check("lb_req_valid", 32'(req_valid), 32'h1);
    check("lb_req_addr", req_addr, 32'h8000_0000);
    check("lb_req_wen", 32'(req_wen), 32'h0);
    check("lb_out_valid_req", 32'(out_valid), 32'h0);
    bus_xfer(32'h80FF_0000);
    check("lb_wb_data", wb_data, 32'hFFFF_FF80);
    check("lb_rd_next", 32'(rd_next), 32'd6);
    finish_op();

    // LBU same address
    start_op(32'h0000_0204, 32'h8000_0003, 32'h0, 3'b100, 1'b0, 1'b1, 5'd7, 1'b1);
    bus_xfer(32'h80FF_0000);
    check("lbu_wb_data", wb_data, 32'h0000_0080);
    finish_op();

    // SH upper half with a 5-cycle grant stall; stray rsp_valid during REQ is ignored
    start_op(32'h0000_0208, 32'h8000_0002, 32'h0000_ABCD, 3'b001, 1'b1, 1'b0, 5'd0, 1'b0);
    check("sh_req_valid", 32'(req_valid), 32'h1);
    check("sh_req_addr", req_addr, 32'h8000_0000);
    check("sh_req_wdata", req_wdata, 32'hABCD_ABCD);
    check("sh_req_wmask", 32'(req_wmask), 32'hC);
    check("sh_req_wen", 32'(req_wen), 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      rsp_valid = (i == 2);
      @(posedge clk);
      #1 check("stall_req_valid", 32'(req_valid), 32'h1);
      check("stall_req_addr", req_addr, 32'h8000_0000);
      check("stall_req_wmask", 32'(req_wmask), 32'hC);
      check("stall_out_valid", 32'(out_valid), 32'h0);
    end
    @(negedge clk) rsp_valid = 1'b0;
    bus_xfer(32'h1234_5678);
    check("sh_wb_data", wb_data, 32'h8000_0002);
    check("sh_R_wen_next", 32'(R_wen_next), 32'h0);
    finish_op();

    // SB into lane 1
    start_op(32'h0000_020C, 32'h0000_1001, 32'h1234_5677, 3'b000, 1'b1, 1'b0, 5'd0, 1'b0);
    check("sb_req_wdata", req_wdata, 32'h7777_7777);
    check("sb_req_wmask", 32'(req_wmask), 32'h2);
    check("sb_req_addr", req_addr, 32'h0000_1000);
    bus_xfer(32'h0);
    finish_op();

    // LH / LHU from upper half
    start_op(32'h0000_0210, 32'h0000_2002, 32'h0, 3'b001, 1'b0, 1'b1, 5'd8, 1'b1);
    bus_xfer(32'h8001_0000);
    check("lh_wb_data", wb_data, 32'hFFFF_8001);
    finish_op();
    start_op(32'h0000_0214, 32'h0000_2002, 32'h0, 3'b101, 1'b0, 1'b1, 5'd8, 1'b1);
    bus_xfer(32'h8001_0000);
    check("lhu_wb_data", wb_data, 32'h0000_8001);
    finish_op();

    // LW with output back-pressure, then back-to-back capture from DONE
    start_op(32'h0000_0218, 32'h0000_3000, 32'h0, 3'b010, 1'b0, 1'b1, 5'd9, 1'b1);
    out_ready = 1'b0;
    bus_xfer(32'hDEAD_BEEF);
    check("lw_wb_data", wb_data, 32'hDEAD_BEEF);
    @(posedge clk);
    #1 check("hold_out_valid", 32'(out_valid), 32'h1);
    check("hold_in_ready", 32'(in_ready), 32'h0);
    check("hold_wb_data", wb_data, 32'hDEAD_BEEF);
    start_op(32'h0000_021C, 32'h0000_0055, 32'h0, 3'b000, 1'b0, 1'b0, 5'd10, 1'b1);
    check("b2b_out_valid", 32'(out_valid), 32'h1);
    check("b2b_wb_data", wb_data, 32'h0000_0055);
    check("b2b_pc_next", pc_next, 32'h0000_021C);
    finish_op();

    // Both enables set behaves as a word store
    start_op(32'h0000_0220, 32'h0000_4004, 32'h1122_3344, 3'b010, 1'b1, 1'b1, 5'd11, 1'b0);
    check("sw_req_wen", 32'(req_wen), 32'h1);
    check("sw_req_wdata", req_wdata, 32'h1122_3344);
    check("sw_req_wmask", 32'(req_wmask), 32'hF);
    bus_xfer(32'hFFFF_FFFF);
    check("sw_wb_data", wb_data, 32'h0000_4004);
    finish_op();

    // Reset while in REQ
    start_op(32'h0000_0224, 32'h0000_0040, 32'h0, 3'b010, 1'b0, 1'b1, 5'd12, 1'b1);
    check("rstreq_req_valid_pre", 32'(req_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1 check("rstreq_req_valid", 32'(req_valid), 32'h0);
    check("rstreq_pc_next", pc_next, 32'h0);
    check("rstreq_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Reset while in WAIT_RSP, late response afterwards is ignored
    start_op(32'h0000_0228, 32'h0000_0044, 32'h0, 3'b010, 1'b0, 1'b1, 5'd13, 1'b1);
    @(negedge clk);
    in_valid  = 1'b0;
    req_ready = 1'b1;
    @(posedge clk);
    #1 check("rstwait_req_valid_pre", 32'(req_valid), 32'h0);
    #2 rst_n = 1'b0;
    #1 check("rstwait_out_valid", 32'(out_valid), 32'h0);
    check("rstwait_req_addr", req_addr, 32'h0);
    check("rstwait_wb_data", wb_data, 32'h0);
    @(negedge clk);
    req_ready = 1'b0;
    rst_n     = 1'b1;
    rsp_valid = 1'b1;
    rsp_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 check("late_rsp_out_valid", 32'(out_valid), 32'h0);
    check("late_rsp_in_ready", 32'(in_ready), 32'h1);
    check("late_rsp_req_valid", 32'(req_valid), 32'h0);
    check("late_rsp_wb_data", wb_data, 32'h0);
    @(negedge clk) rsp_valid = 1'b0;

`ifdef MEM_MISALIGN_CHECK_EN
    start_op(32'h0000_0230, 32'h0000_0002, 32'h0, 3'b010, 1'b0, 1'b1, 5'd14, 1'b1);
    check("mis_req_valid", 32'(req_valid), 32'h0);
    check("mis_out_valid", 32'(out_valid), 32'h1);
    check("mis_err", 32'(misalign_err), 32'h1);
    check("mis_R_wen_next", 32'(R_wen_next), 32'h0);
    finish_op();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
